// File: rtl/instr_item_encoder.sv
// Generic FIFO plus RV32I item encoder; one cycle accept-to-output when the FIFO is empty.
// Backpressure: in_ready drops while the FIFO is full, and out_* hold while out_ready is low.
module fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage is not reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module instr_item_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_instr,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [WORD_SIZE-1:0] in_imm,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_addr,
  output logic [WORD_SIZE-1:0] out_word,
  output logic                 done,
  output logic                 err_illegal,
  output logic [7:0]           illegal_cnt
);
  typedef enum logic [5:0] {
    ADDI, SLTI, SLTIU, ORI, XORI, ANDI, SLLI, SRLI, SRAI, JALR,
    LW, LB, LH, LBU, LHU, ADD, SUB, SLL, SLT, SLTU,
    XOR, SRL, SRA, OR, AND, LUI, AUIPC, JAL, SW, SB,
    SH, BEQ, BNE, BLT, BLTU, BGE, BGEU, NO_INST
  } instr_e;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NOP, FMT_ILL
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  fmt_e        fmt;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic [31:0] word;
  logic        illegal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [32:0] head_dat;
  logic [WORD_SIZE-1:0] addr_q;

  assign imm32 = 32'(in_imm);

  always_comb begin
    fmt = FMT_ILL;
    op  = 7'b0;
    f3  = 3'b0;
    f7  = 7'b0;
    case (in_instr)
      ADDI:    begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b000; end
      SLTI:    begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b010; end
      SLTIU:   begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b011; end
      XORI:    begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b100; end
      ORI:     begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b110; end
      ANDI:    begin fmt = FMT_I;  op = OP_IMM; f3 = 3'b111; end
      SLLI:    begin fmt = FMT_SH; op = OP_IMM; f3 = 3'b001; end
      SRLI:    begin fmt = FMT_SH; op = OP_IMM; f3 = 3'b101; end
      SRAI:    begin fmt = FMT_SH; op = OP_IMM; f3 = 3'b101; f7 = F7_ALT; end
      JALR:    begin fmt = FMT_I;  op = OP_JLR; f3 = 3'b000; end
      LB:      begin fmt = FMT_I;  op = OP_LD;  f3 = 3'b000; end
      LH:      begin fmt = FMT_I;  op = OP_LD;  f3 = 3'b001; end
      LW:      begin fmt = FMT_I;  op = OP_LD;  f3 = 3'b010; end
      LBU:     begin fmt = FMT_I;  op = OP_LD;  f3 = 3'b100; end
      LHU:     begin fmt = FMT_I;  op = OP_LD;  f3 = 3'b101; end
      ADD:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b000; end
      SUB:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b000; f7 = F7_ALT; end
      SLL:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b001; end
      SLT:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b010; end
      SLTU:    begin fmt = FMT_R;  op = OP_REG; f3 = 3'b011; end
      XOR:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b100; end
      SRL:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b101; end
      SRA:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b101; f7 = F7_ALT; end
      OR:      begin fmt = FMT_R;  op = OP_REG; f3 = 3'b110; end
      AND:     begin fmt = FMT_R;  op = OP_REG; f3 = 3'b111; end
      LUI:     begin fmt = FMT_U;  op = OP_LUI; end
      AUIPC:   begin fmt = FMT_U;  op = OP_AUI; end
      JAL:     begin fmt = FMT_J;  op = OP_JAL; end
      SB:      begin fmt = FMT_S;  op = OP_ST;  f3 = 3'b000; end
      SH:      begin fmt = FMT_S;  op = OP_ST;  f3 = 3'b001; end
      SW:      begin fmt = FMT_S;  op = OP_ST;  f3 = 3'b010; end
      BEQ:     begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b000; end
      BNE:     begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b001; end
      BLT:     begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b100; end
      BGE:     begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b101; end
      BLTU:    begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b110; end
      BGEU:    begin fmt = FMT_B;  op = OP_BR;  f3 = 3'b111; end
      NO_INST: fmt = FMT_NOP;
      default: fmt = FMT_ILL;
    endcase
  end

  // Fields a format does not carry are simply left out of its concatenation.
  always_comb begin
    word = 32'h0000_0013;
    case (fmt)
      FMT_R:   word = {f7, in_rs2, in_rs1, f3, in_rd, op};
      FMT_I:   word = {imm32[11:0], in_rs1, f3, in_rd, op};
      FMT_SH:  word = {f7, imm32[4:0], in_rs1, f3, in_rd, op};
      FMT_S:   word = {imm32[11:5], in_rs2, in_rs1, f3, imm32[4:0], op};
      FMT_B:   word = {imm32[12], imm32[10:5], in_rs2, in_rs1, f3, imm32[4:1], imm32[11], op};
      FMT_U:   word = {imm32[31:12], in_rd, op};
      FMT_J:   word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], in_rd, op};
      default: word = 32'h0000_0013;
    endcase
  end

  assign illegal = (fmt == FMT_ILL);
  assign accept  = in_valid && in_ready;
  assign push    = accept && !illegal;
  assign pop     = out_valid && out_ready;

  fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({in_last, word}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (full),
    .empty    (empty)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_word  = out_valid ? WORD_SIZE'(head_dat[31:0]) : '0;
  assign out_addr  = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= WORD_SIZE'(BASE_ADDR);
      done        <= 1'b0;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      done        <= pop && head_dat[32];
      err_illegal <= accept && illegal;
      if (accept && illegal && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
      if (pop) addr_q <= head_dat[32] ? WORD_SIZE'(BASE_ADDR) : addr_q + WORD_SIZE'(4);
    end
  end
endmodule

// File: tb/tb_instr_item_encoder.sv
// Randomized scoreboard bench for instr_item_encoder against a table-driven RV32I model.
module tb_instr_item_encoder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [5:0]  in_instr;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_word;
  logic        done, err_illegal;
  logic [7:0]  illegal_cnt;

  instr_item_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WORD_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_word(out_word), .done(done), .err_illegal(err_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] word; bit last; } exp_t;
  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] prog_addr = BASE;
  int ordy_mode = 1;

  // One character per code: I=I-type, H=shift, R, S, B, U, J, N=nop.
  string fmt_s = "IIIIIIHHHIIIIIIRRRRRRRRRRUUJSSSBBBBBBN";
  int f3_t[38] = '{0,2,3,6,4,7, 1,5,5, 0, 2,0,1,4,5,
                   0,0,1,2,3,4,5,5,6,7, 0,0,0, 2,0,1, 0,1,4,6,5,7, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int code, input logic [31:0] rs1,
      input logic [31:0] rs2, input logic [31:0] rd, input logic [31:0] imm);
    logic [31:0] op, f3, f7, w;
    byte fc;
    fc = fmt_s[code];
    f3 = f3_t[code];
    f7 = (code == 8 || code == 16 || code == 22) ? 32'h20 : 32'h0;
    case (fc)
      "R": op = 32'h33;
      "S": op = 32'h23;
      "B": op = 32'h63;
      "J": op = 32'h6F;
      "U": op = (code == 25) ? 32'h37 : 32'h17;
      default: op = (code == 9) ? 32'h67 : (code >= 10 && code <= 14) ? 32'h03 : 32'h13;
    endcase
    w = op | (f3 << 12);
    case (fc)
      "R": w = w | (rd << 7) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      "I": w = w | (rd << 7) | (rs1 << 15) | ((imm & 32'hFFF) << 20);
      "H": w = w | (rd << 7) | (rs1 << 15) | ((imm & 31) << 20) | (f7 << 25);
      "S": w = w | (rs1 << 15) | (rs2 << 20) | ((imm & 31) << 7) | (((imm >> 5) & 127) << 25);
      "B": w = w | (rs1 << 15) | (rs2 << 20) | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8)
             | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      "U": w = w | (rd << 7) | (imm & 32'hFFFF_F000);
      "J": w = w | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
             | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  // Driver: called at posedge+1, returns at posedge+1 after the accepting edge.
  task automatic send(input int code, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [4:0] rd, input logic [31:0] imm, input bit last,
      input bit use_exp, input logic [31:0] exp_word);
    exp_t e;
    int wait_cyc = 0;
    in_valid = 1'b1; in_instr = 6'(code); in_rs1 = rs1; in_rs2 = rs2;
    in_rd = rd; in_imm = imm; in_last = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      wait_cyc++;
      if (wait_cyc > 2000) begin
        check("send_timeout", 32'(wait_cyc), 32'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (code < 38) begin
      e.addr = prog_addr;
      e.word = use_exp ? exp_word : ref_encode(code, 32'(rs1), 32'(rs2), 32'(rd), imm);
      e.last = last;
      exp_q.push_back(e);
      prog_addr = last ? BASE : prog_addr + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit allow_illegal);
    int code;
    code = (allow_illegal && $urandom_range(0, 15) == 0) ? int'($urandom_range(38, 63))
                                                          : int'($urandom_range(0, 37));
    send(code, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
         $urandom_range(0, 7) == 0, 1'b0, 32'h0);
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: occupancy, side-band pulses and the word scoreboard.
  initial begin
    int occ = 0;
    int cnt_exp = 0;
    bit done_exp = 0;
    bit err_exp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        occ = 0; cnt_exp = 0; done_exp = 0; err_exp = 0;
      end else begin
        check("done", 32'(done), 32'(done_exp));
        check("err_illegal", 32'(err_illegal), 32'(err_exp));
        check("illegal_cnt", 32'(illegal_cnt), 32'(cnt_exp));
        check("out_valid", 32'(out_valid), 32'(occ > 0));
        check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
        done_exp = 0;
        err_exp = 0;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", out_word, 32'hxxxx_xxxx);
          end else begin
            check("out_word", out_word, exp_q[0].word);
            check("out_addr", out_addr, exp_q[0].addr);
            if (out_ready) begin
              done_exp = exp_q[0].last;
              void'(exp_q.pop_front());
            end
          end
          if (out_ready && occ > 0) occ--;
        end
        if (in_valid && in_ready) begin
          if (in_instr >= 6'd38) begin
            err_exp = 1;
            if (cnt_exp < 255) cnt_exp++;
          end else begin
            occ++;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; in_imm = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_addr", out_addr, BASE);
    check("rst_out_word", out_word, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_illegal), 32'd0);
    check("rst_cnt", 32'(illegal_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1, 1'b1, 32'h0050_0093);
    send(15, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b1, 32'h0020_81B3);
    send(28, 5'd1, 5'd2, 5'd7, 32'd8, 1'b1, 1'b1, 32'h0020_A423);
    send(31, 5'd1, 5'd2, 5'd9, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE20_8EE3);
    send(25, 5'd3, 5'd4, 5'd5, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_52B7);
    send(27, 5'd9, 5'd6, 5'd1, 32'd8, 1'b1, 1'b1, 32'h0080_00EF);
    drain();

    ordy_mode = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(int'($urandom_range(0, 37)), 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, i == 5, 1'b0, 32'h0);
        end
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        ordy_mode = 1;
      end
    join
    drain();

    send(45, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 1'b0, 32'h0);
    send(37, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0013);
    send(0, 5'd2, 5'd0, 5'd4, 32'h0000_0FFF, 1'b0, 1'b0, 32'h0);
    drain();

    ordy_mode = 2;
    repeat (300) send_rand(1'b1);
    drain();

    ordy_mode = 1;
    repeat (260) send(int'($urandom_range(38, 63)), 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0);
    drain();
    check("illegal_sat", 32'(illegal_cnt), 32'd255);

    ordy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_rand(1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(illegal_cnt), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    prog_addr = BASE;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy_mode = 1;
    send(0, 5'd1, 5'd0, 5'd2, 32'd7, 1'b0, 1'b0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_item_encoder.md
Name: instr_item_encoder

Overview:
- Stimulus-side stage that converts decoded instruction items (opcode code, rs1, rs2, rd, imm) into RV32I machine words.
- Addresses each word and streams it toward the DUT instruction memory loader.
- Sits between the sequence/item generator and the instruction-memory write port.
- Buffers encoded words in a FIFO and signals program completion.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- BASE_ADDR, 32'h0000_0000, byte address of first emitted word
- WORD_SIZE, 32, data/address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  item offered
- in_ready  out  1  item accepted when in_valid&&in_ready
- in_instr  in  6  instruction code, ordinal: ADDI0 SLTI1 SLTIU2 ORI3 XORI4 ANDI5 SLLI6 SRLI7 SRAI8 JALR9 LW10 LB11 LH12 LBU13 LHU14 ADD15 SUB16 SLL17 SLT18 SLTU19 XOR20 SRL21 SRA22 OR23 AND24 LUI25 AUIPC26 JAL27 SW28 SB29 SH30 BEQ31 BNE32 BLT33 BLTU34 BGE35 BGEU36 NO_INST37
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_imm  in  WORD_SIZE  immediate
- in_last  in  1  item is final of program
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word
- out_addr  out  WORD_SIZE  byte address of word
- out_word  out  WORD_SIZE  encoded instruction
- done  out  1  one-cycle pulse after last word consumed
- err_illegal  out  1  one-cycle pulse on illegal code (38–63) accepted
- illegal_cnt  out  8  saturating count of illegal codes

Behaviour:
- Reset: in_ready=1, out_valid=0, out_addr=BASE_ADDR, out_word=0, done=0, err_illegal=0, illegal_cnt=0; FIFO emptied; address counter=BASE_ADDR. Reset mid-transfer discards all buffered words.
- Encoding is combinational at input; word plus last flag pushed into FIFO on accept. One-cycle latency: an item accepted in cycle N appears on out_* in N+1 if FIFO was empty.
- Formats:
  - OP-IMM 0010011, f3: ADDI000 SLTI010 SLTIU011 XORI100 ORI110 ANDI111, imm[11:0].
  - Shifts: SLLI001, SRLI101 f7=0000000, SRAI101 f7=0100000, shamt=imm[4:0].
  - OP 0110011, f3 as OP-IMM, SLL001 SRL/SRA101. SUB/SRA f7=0100000, others 0.
  - LOAD 0000011: LB000 LH001 LW010 LBU100 LHU101.
  - JALR 1100111 f3=000.
  - STORE 0100011: SB000 SH001 SW010, imm split [11:5]/[4:0].
  - BRANCH 1100011: BEQ000 BNE001 BLT100 BGE101 BLTU110 BGEU111, imm[12|10:5|4:1|11]. imm[0] ignored.
  - LUI 0110111 and AUIPC 0010111 take imm[31:12].
  - JAL 1101111 takes imm[20|10:1|11|19:12].
  - Unused fields (rd for S/B, rs2 for I/U/J, rs1 for U/J) are forced to 0 regardless of input.
- NO_INST encodes 32'h0000_0013 (NOP).
- Codes 38–63: item consumed (handshake completes) but not pushed. err_illegal pulses next cycle. illegal_cnt increments, saturating at 255. If in_last is set on an illegal item, the flag is lost and done does not fire.
- FIFO:
  - in_ready = !full.
  - out_valid = !empty.
  - Simultaneous push and pop while full is not permitted, because in_ready is already low.
  - Simultaneous push and pop at any other occupancy keeps the count.
  - Pointers wrap modulo DEPTH.
- out_addr increments by 4 on each out_valid&&out_ready, wrapping at 2^WORD_SIZE. Output is held stable while out_valid&&!out_ready.
- Popping a word tagged last:
  - done pulses in the following cycle.
  - Address counter returns to BASE_ADDR.
  - Subsequent items start a new program.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, out_ready=1 -> out_word=0x00500093, out_addr=0x0, visible one cycle after accept.
- ADD rd=3 rs1=1 rs2=2, then SW rs1=1 rs2=2 imm=8 -> words 0x002081B3 at 0x0 and 0x0020A423 at 0x4.
- BEQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3. LUI rd=5 imm=0x12345000 -> 0x123452B7. JAL rd=1 imm=8 -> 0x008000EF.
- Hold out_ready=0 and offer 6 items -> in_ready drops after 4 accepts, out_word held. Release -> words drained in order at addresses 0x0–0x14, no loss or duplication.
- in_instr=45 -> err_illegal pulse, illegal_cnt=1, no word emitted. NO_INST -> 0x00000013. Item with in_last=1 -> done one cycle after its pop, next word at BASE_ADDR.
- Assert rst_n=0 asynchronously with 3 words buffered -> out_valid=0 immediately, illegal_cnt=0, first post-reset word at BASE_ADDR.
